// File: rtl/monitor_event_scheduler_if.sv
// Event-source and monitor-facing signal bundle for monitor_event_scheduler.
// The master side drives input-stream events; the slave side is the scheduler.
interface monitor_event_scheduler_if #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic signed [DATA_W-1:0] in0_data;
  logic                     in0_valid;
  logic signed [DATA_W-1:0] in1_data;
  logic                     in1_valid;
  logic signed [DATA_W-1:0] input_0;
  logic                     new_input_0;
  logic signed [DATA_W-1:0] input_1;
  logic                     new_input_1;
  logic                     tick;
  logic                     dropped;
  logic [LVL_W-1:0]         fifo_level;

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid,
    input  input_0, new_input_0, input_1, new_input_1, tick, dropped, fifo_level
  );

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid,
    output input_0, new_input_0, input_1, new_input_1, tick, dropped, fifo_level
  );
endinterface

// File: rtl/monitor_event_scheduler.sv
// Queues input-stream events and issues them to the monitor one per slot,
// interleaving a periodic evaluation tick that always wins a tie.
module monitor_event_scheduler #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int PERIOD     = 500,
  parameter int MIN_GAP    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  monitor_event_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(PERIOD);
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef struct packed {
    logic [1:0]        mask;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE_TICK, ISSUE_EV, GAP} state_t;

  entry_t            mem_q [FIFO_DEPTH];
  entry_t            new_entry;
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  state_t            state_q, state_d;
  logic              tp_q, tp_d;
  logic              dropped_q, dropped_d;
  logic [DATA_W-1:0] in0_q, in0_d, in1_q, in1_d;
  logic              new0_q, new0_d, new1_q, new1_d, tick_q, tick_d;
  logic              push, pop, full, empty, accept, wrap;

  assign push   = en & (bus.in0_valid | bus.in1_valid);
  assign pop    = en & (state_q == ISSUE_EV);
  assign full   = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty  = (level_q == '0);
  // A full FIFO still takes the push when the head leaves on the same edge.
  assign accept = push & (~full | pop);
  assign wrap   = (cnt_q == CNT_W'(PERIOD - 1));
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    new_entry.mask = {bus.in1_valid, bus.in0_valid};
    new_entry.d0   = bus.in0_valid ? bus.in0_data : '0;
    new_entry.d1   = bus.in1_valid ? bus.in1_data : '0;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    state_d   = state_q;
    tp_d      = tp_q;
    dropped_d = dropped_q | (push & full & ~pop);
    in0_d     = in0_q;
    in1_d     = in1_q;
    new0_d    = new0_q;
    new1_d    = new1_q;
    tick_d    = tick_q;
    if (en) begin
      in0_d  = '0;
      in1_d  = '0;
      new0_d = 1'b0;
      new1_d = 1'b0;
      tick_d = 1'b0;
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
      if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({accept, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      // A wrap on the very edge that issues the tick re-arms it.
      tp_d = wrap | (tp_q & (state_q != ISSUE_TICK));
      case (state_q)
        IDLE: begin
          if (tp_q)        state_d = ISSUE_TICK;
          else if (!empty) state_d = ISSUE_EV;
        end
        ISSUE_TICK: begin
          tick_d  = 1'b1;
          gap_d   = '0;
          state_d = (MIN_GAP > 1) ? GAP : IDLE;
        end
        ISSUE_EV: begin
          new0_d  = head.mask[0];
          new1_d  = head.mask[1];
          in0_d   = head.d0;
          in1_d   = head.d1;
          gap_d   = '0;
          state_d = (MIN_GAP > 1) ? GAP : IDLE;
        end
        GAP: begin
          if (gap_q == GAP_W'(MIN_GAP - 2)) state_d = IDLE;
          else                              gap_d   = gap_q + GAP_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      state_q   <= IDLE;
      tp_q      <= 1'b0;
      dropped_q <= 1'b0;
      in0_q     <= '0;
      in1_q     <= '0;
      new0_q    <= 1'b0;
      new1_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      state_q   <= state_d;
      tp_q      <= tp_d;
      dropped_q <= dropped_d;
      in0_q     <= in0_d;
      in1_q     <= in1_d;
      new0_q    <= new0_d;
      new1_q    <= new1_d;
      tick_q    <= tick_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= new_entry;
  end

  assign bus.input_0     = in0_q;
  assign bus.input_1     = in1_q;
  assign bus.new_input_0 = new0_q & en;
  assign bus.new_input_1 = new1_q & en;
  assign bus.tick        = tick_q & en;
  assign bus.dropped     = dropped_q;
  assign bus.fifo_level  = level_q;
endmodule

// File: tb/tb_monitor_event_scheduler.sv
// Scoreboard bench for monitor_event_scheduler: directed stimulus pushes
// expected issue slots (with their edge number); a negedge monitor pops them.
module tb_monitor_event_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic en;
  int   edgeNum = 0;
  int   testsRun = 0;
  int   failures = 0;
  int   maxLevel = 0;
  bit   trackLevel = 1'b0;

  typedef struct {
    bit          isTick;
    bit [1:0]    mask;
    logic [63:0] d0;
    logic [63:0] d1;
    int          outEdge;
  } exp_t;

  exp_t expQ[$];
  exp_t monItem;

  monitor_event_scheduler_if #(.DATA_W(64), .FIFO_DEPTH(4)) bus ();

  monitor_event_scheduler #(
    .DATA_W(64), .FIFO_DEPTH(4), .PERIOD(500), .MIN_GAP(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en (en),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) edgeNum <= 0;
    else     edgeNum <= edgeNum + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name,
               $signed(actual), $signed(expected), edgeNum);
    end
  endtask

  task automatic expectItem(input bit isTick, input bit [1:0] mask,
                            input logic [63:0] d0, input logic [63:0] d1,
                            input int outEdge);
    exp_t e;
    e.isTick  = isTick;
    e.mask    = mask;
    e.d0      = d0;
    e.d1      = d1;
    e.outEdge = outEdge;
    expQ.push_back(e);
  endtask

  // Drives one cycle of input; returns just after the edge that sampled it.
  task automatic applyStimulus(input logic v0, input logic [63:0] d0,
                               input logic v1, input logic [63:0] d1);
    bus.in0_valid = v0;
    bus.in0_data  = d0;
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    @(posedge clk);
    #1;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in0_data  = '0;
    bus.in1_data  = '0;
  endtask

  task automatic waitEdge(input int n);
    int guard = 0;
    while (edgeNum != n && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 5000) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL waitEdge: timed out at edge %0d, wanted %0d", edgeNum, n);
    end
  endtask

  always @(negedge clk) begin
    if (trackLevel && int'(bus.fifo_level) > maxLevel) maxLevel = int'(bus.fifo_level);
    if (bus.tick === 1'b1 || bus.new_input_0 === 1'b1 || bus.new_input_1 === 1'b1) begin
      if (expQ.size() == 0) begin
        testsRun++;
        failures++;
        $display("[TB] FAIL unexpectedIssue: tick=%0b new0=%0b new1=%0b at edge %0d, expected none",
                 bus.tick, bus.new_input_0, bus.new_input_1, edgeNum);
      end else begin
        monItem = expQ.pop_front();
        checkOutput("issueEdge", 64'(edgeNum), 64'(monItem.outEdge));
        checkOutput("tick", 64'(bus.tick), 64'(monItem.isTick));
        checkOutput("newInput0", 64'(bus.new_input_0), 64'(monItem.mask[0]));
        checkOutput("newInput1", 64'(bus.new_input_1), 64'(monItem.mask[1]));
        checkOutput("input0", bus.input_0, monItem.d0);
        checkOutput("input1", bus.input_1, monItem.d1);
      end
    end
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in0_data  = '0;
    bus.in1_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetTick", 64'(bus.tick), 64'd0);
    checkOutput("resetNew0", 64'(bus.new_input_0), 64'd0);
    checkOutput("resetNew1", 64'(bus.new_input_1), 64'd0);
    checkOutput("resetInput0", bus.input_0, 64'd0);
    checkOutput("resetInput1", bus.input_1, 64'd0);
    checkOutput("resetDropped", 64'(bus.dropped), 64'd0);
    checkOutput("resetLevel", 64'(bus.fifo_level), 64'd0);
    rst = 1'b0;

    // Idle: tick_pending at edges 500 and 1000, tick visible two edges later.
    expectItem(1'b1, 2'b00, 64'd0, 64'd0, 502);
    expectItem(1'b1, 2'b00, 64'd0, 64'd0, 1002);
    waitEdge(1010);
    checkOutput("idleDropped", 64'(bus.dropped), 64'd0);
    checkOutput("idleTicksSeen", 64'(expQ.size()), 64'd0);

    // Single event on stream 0.
    waitEdge(1100);
    expectItem(1'b0, 2'b01, 64'd25, 64'd0, 1103);
    applyStimulus(1'b1, 64'd25, 1'b0, 64'd0);

    // Both streams in one cycle form a single event.
    waitEdge(1200);
    expectItem(1'b0, 2'b11, 64'd5, 64'(-3), 1203);
    maxLevel   = 0;
    trackLevel = 1'b1;
    applyStimulus(1'b1, 64'd5, 1'b1, 64'(-3));
    checkOutput("bothLevel", 64'(bus.fifo_level), 64'd1);
    waitEdge(1210);
    trackLevel = 1'b0;
    checkOutput("bothMaxLevel", 64'(maxLevel), 64'd1);

    // Burst 1..7 on edges 1301..1307: pops at 1303,1306,... so value 6 is
    // accepted alongside a pop and value 7 meets a full FIFO with no pop.
    waitEdge(1300);
    for (int v = 1; v <= 6; v++) expectItem(1'b0, 2'b01, 64'(v), 64'd0, 1303 + 3 * (v - 1));
    maxLevel   = 0;
    trackLevel = 1'b1;
    for (int v = 1; v <= 7; v++) begin
      applyStimulus(1'b1, 64'(v), 1'b0, 64'd0);
      if (v == 6) checkOutput("burstDroppedBefore", 64'(bus.dropped), 64'd0);
      if (v == 7) checkOutput("burstDroppedAfter", 64'(bus.dropped), 64'd1);
    end
    waitEdge(1320);
    trackLevel = 1'b0;
    checkOutput("burstMaxLevel", 64'(maxLevel), 64'd4);
    checkOutput("burstLevelEnd", 64'(bus.fifo_level), 64'd0);

    // Event pushed on the edge tick_pending is set: tick first, event 3 later.
    waitEdge(1499);
    expectItem(1'b1, 2'b00, 64'd0, 64'd0, 1502);
    expectItem(1'b0, 2'b01, 64'd99, 64'd0, 1505);
    applyStimulus(1'b1, 64'd99, 1'b0, 64'd0);

    // Freeze edges 1603..1652 with two events queued; everything slips 50.
    waitEdge(1600);
    expectItem(1'b0, 2'b01, 64'd11, 64'd0, 1653);
    expectItem(1'b0, 2'b01, 64'd22, 64'd0, 1656);
    expectItem(1'b1, 2'b00, 64'd0, 64'd0, 2052);
    applyStimulus(1'b1, 64'd11, 1'b0, 64'd0);
    applyStimulus(1'b1, 64'd22, 1'b0, 64'd0);
    en = 1'b0;
    waitEdge(1627);
    checkOutput("freezeLevel", 64'(bus.fifo_level), 64'd2);
    waitEdge(1652);
    en = 1'b1;

    // Reset during the GAP after event 77 discards queued event 88.
    waitEdge(2099);
    expectItem(1'b0, 2'b01, 64'd77, 64'd0, 2102);
    applyStimulus(1'b1, 64'd77, 1'b0, 64'd0);
    applyStimulus(1'b1, 64'd88, 1'b0, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("preResetLevel", 64'(bus.fifo_level), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midResetTick", 64'(bus.tick), 64'd0);
    checkOutput("midResetNew0", 64'(bus.new_input_0), 64'd0);
    checkOutput("midResetInput0", bus.input_0, 64'd0);
    checkOutput("midResetLevel", 64'(bus.fifo_level), 64'd0);
    checkOutput("midResetDropped", 64'(bus.dropped), 64'd0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end
endmodule
